// File: rtl/subtr_seq_pkg.sv
// Shared definitions for the sequential subtractor: FSM encodings and flag bit order.
package subtr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flag vector order is {ovf, neg, zero, bout}
    localparam int FLAG_BOUT = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_NEG  = 2;
    localparam int FLAG_OVF  = 3;
    localparam int FLAG_W    = 4;

    function automatic int step_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/subtr_digit.sv
// Combinational DIGIT-bit subtract slice: {bout, diff} = a - b - bin.
module subtr_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};

endmodule

// File: rtl/subtr_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock with a registered borrow.
// Operands shift right each step; the partial result is assembled in r_acc and published on the last step.
module subtr_seq
    import subtr_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int STEPS  = WIDTH / DIGIT;
    localparam int STEP_W = step_width(STEPS);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("subtr_seq: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [STEP_W-1:0]  r_step;
    logic               r_borrow;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_diff;
    logic [FLAG_W-1:0]  r_flags;

    logic [DIGIT-1:0]   w_d;
    logic               w_br;
    logic [WIDTH-1:0]   w_res;
    logic               w_accept;
    logic               w_last;

    subtr_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .bin  (r_borrow),
        .diff (w_d),
        .bout (w_br)
    );

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_step == STEP_W'(STEPS - 1));
    // New digit enters at the top; after STEPS shifts digit 0 sits at the bottom.
    assign w_res    = (r_acc >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step   <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_acc    <= '0;
            r_diff   <= '0;
            r_flags  <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_borrow <= bin;
            r_step   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_acc    <= w_res;
            r_borrow <= w_br;
            r_step   <= r_step + STEP_W'(1);
            if (w_last) begin
                r_diff             <= w_res;
                r_flags[FLAG_BOUT] <= w_br;
                r_flags[FLAG_ZERO] <= (w_res == '0);
                r_flags[FLAG_NEG]  <= w_res[WIDTH-1];
                r_flags[FLAG_OVF]  <= (r_a_msb != r_b_msb) && (w_res[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign diff      = r_diff;
    assign bout      = r_flags[FLAG_BOUT];
    assign zero      = r_flags[FLAG_ZERO];
    assign neg       = r_flags[FLAG_NEG];
    assign ovf       = r_flags[FLAG_OVF];

endmodule
